// File: rtl/ep_txtsu_source.sv
// Endpoint TX timestamp source: pairs committed TX-OOB frames with PCS
// timestamps and hands {port, fid, tsval} records to the TXTSU consumer.
module ep_txtsu_source #(
    parameter logic [4:0]  g_PORT_ID       = 5'd0,
    parameter int unsigned g_PENDING_DEPTH = 4,
    parameter int unsigned g_QUEUE_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        frame_commit_i,
    input  logic        frame_has_oob_i,
    input  logic [15:0] frame_fid_i,
    input  logic        ts_valid_i,
    input  logic [3:0]  ts_f_i,
    input  logic [27:0] ts_r_i,
    output logic [4:0]  txtsu_port_id_o,
    output logic [15:0] txtsu_fid_o,
    output logic [31:0] txtsu_tsval_o,
    output logic        txtsu_valid_o,
    input  logic        txtsu_ack_i,
    output logic [7:0]  drop_cnt_o
);

    localparam int PAW = $clog2(g_PENDING_DEPTH);
    localparam int QAW = $clog2(g_QUEUE_DEPTH);
    localparam logic [PAW:0] P_ONE = {{PAW{1'b0}}, 1'b1};
    localparam logic [QAW:0] Q_ONE = {{QAW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t state_q;

    // Pending FIFO: {has_oob, fid} per committed frame
    logic [16:0]  pend_mem_q [g_PENDING_DEPTH];
    logic [PAW:0] pend_wr_q, pend_wr_d;
    logic [PAW:0] pend_rd_q, pend_rd_d;
    logic         pend_empty, pend_full;
    logic         pend_push, pend_pop;
    logic [16:0]  pend_head;

    // Record FIFO: {fid, tsval} awaiting presentation and ack
    logic [47:0]  rec_mem_q [g_QUEUE_DEPTH];
    logic [QAW:0] rec_wr_q, rec_wr_d;
    logic [QAW:0] rec_rd_q, rec_rd_d;
    logic         rec_empty, rec_full;
    logic         rec_push_req, rec_push, rec_pop;
    logic [47:0]  rec_head;

    logic         drop_commit, drop_orphan, drop_rec;
    logic [1:0]   drop_inc;
    logic [8:0]   drop_sum;
    logic [7:0]   drop_q, drop_d;

    logic         valid_q;
    logic [4:0]   port_q;
    logic [15:0]  fid_q;
    logic [31:0]  tsval_q;

    always_comb begin
        pend_empty = (pend_wr_q == pend_rd_q);
        pend_full  = (pend_wr_q[PAW] != pend_rd_q[PAW]) &&
                     (pend_wr_q[PAW-1:0] == pend_rd_q[PAW-1:0]);
        pend_head  = pend_mem_q[pend_rd_q[PAW-1:0]];
        // A same-cycle ts always targets the entry already at the head
        pend_pop   = ts_valid_i && !pend_empty;
        pend_push  = frame_commit_i && (!pend_full || pend_pop);
        pend_wr_d  = pend_push ? pend_wr_q + P_ONE : pend_wr_q;
        pend_rd_d  = pend_pop  ? pend_rd_q + P_ONE : pend_rd_q;
    end

    always_comb begin
        rec_empty    = (rec_wr_q == rec_rd_q);
        rec_full     = (rec_wr_q[QAW] != rec_rd_q[QAW]) &&
                       (rec_wr_q[QAW-1:0] == rec_rd_q[QAW-1:0]);
        rec_head     = rec_mem_q[rec_rd_q[QAW-1:0]];
        rec_pop      = (state_q == S_PRESENT) && txtsu_ack_i;
        rec_push_req = pend_pop && pend_head[16];
        rec_push     = rec_push_req && (!rec_full || rec_pop);
        rec_wr_d     = rec_push ? rec_wr_q + Q_ONE : rec_wr_q;
        rec_rd_d     = rec_pop  ? rec_rd_q + Q_ONE : rec_rd_q;
    end

    always_comb begin
        drop_commit = frame_commit_i && pend_full && !pend_pop;
        drop_orphan = ts_valid_i && pend_empty;
        drop_rec    = rec_push_req && rec_full && !rec_pop;
        drop_inc    = {1'b0, drop_commit} + {1'b0, drop_orphan}
                    + {1'b0, drop_rec};
        drop_sum    = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (pend_push)
            pend_mem_q[pend_wr_q[PAW-1:0]] <= {frame_has_oob_i, frame_fid_i};
        if (rec_push)
            rec_mem_q[rec_wr_q[QAW-1:0]] <= {pend_head[15:0], ts_f_i, ts_r_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_wr_q <= '0;
            pend_rd_q <= '0;
            rec_wr_q  <= '0;
            rec_rd_q  <= '0;
            drop_q    <= '0;
        end else begin
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            rec_wr_q  <= rec_wr_d;
            rec_rd_q  <= rec_rd_d;
            drop_q    <= drop_d;
        end
    end

    // Head record stays in the FIFO until acked; output regs hold a copy
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            port_q  <= '0;
            fid_q   <= '0;
            tsval_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rec_empty) begin
                        state_q <= S_PRESENT;
                        valid_q <= 1'b1;
                        port_q  <= g_PORT_ID;
                        fid_q   <= rec_head[47:32];
                        tsval_q <= rec_head[31:0];
                    end
                end
                S_PRESENT: begin
                    if (txtsu_ack_i) begin
                        state_q <= S_GAP;
                        valid_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign txtsu_port_id_o = port_q;
    assign txtsu_fid_o     = fid_q;
    assign txtsu_tsval_o   = tsval_q;
    assign txtsu_valid_o   = valid_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_ep_txtsu_source.sv
// Directed bench for ep_txtsu_source with a record scoreboard.
module tb_ep_txtsu_source;

    localparam logic [4:0] PORT = 5'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit, has_oob, ts_valid, ack;
    logic [15:0] fid_in;
    logic [3:0]  ts_f;
    logic [27:0] ts_r;
    logic [4:0]  port_o;
    logic [15:0] fid_o;
    logic [31:0] tsval_o;
    logic        valid_o;
    logic [7:0]  drop_o;

    int n_vec = 0;
    int n_err = 0;
    logic [47:0] sb[$];

    always #5 clk = ~clk;

    ep_txtsu_source #(
        .g_PORT_ID(PORT),
        .g_PENDING_DEPTH(4),
        .g_QUEUE_DEPTH(8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .frame_commit_i(commit),
        .frame_has_oob_i(has_oob),
        .frame_fid_i(fid_in),
        .ts_valid_i(ts_valid),
        .ts_f_i(ts_f),
        .ts_r_i(ts_r),
        .txtsu_port_id_o(port_o),
        .txtsu_fid_o(fid_o),
        .txtsu_tsval_o(tsval_o),
        .txtsu_valid_o(valid_o),
        .txtsu_ack_i(ack),
        .drop_cnt_o(drop_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_commit(input logic oob, input logic [15:0] f);
        @(negedge clk);
        commit = 1'b1; has_oob = oob; fid_in = f;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic do_ts(input logic [3:0] f, input logic [27:0] r);
        @(negedge clk);
        ts_valid = 1'b1; ts_f = f; ts_r = r;
        @(negedge clk);
        ts_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic recv(input int ack_dly);
        bit ok;
        logic [47:0] e;
        wait_valid(ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            chk("unexpected_record", {16'd0, fid_o, tsval_o}, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk("rec_fid", fid_o, e[47:32]);
        chk("rec_tsval", tsval_o, e[31:0]);
        chk("rec_port", port_o, PORT);
        repeat (ack_dly) begin
            @(negedge clk);
            chk("hold_valid", valid_o, 1'b1);
            chk("hold_fid", fid_o, e[47:32]);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("gap_valid_low", valid_o, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_fid", fid_o, 16'd0);
        chk("rst_tsval", tsval_o, 32'd0);
        chk("rst_port", port_o, 5'd0);
        chk("rst_drop", drop_o, 8'd0);
    endtask

    initial begin
        bit ok;
        logic [47:0] e;
        rst_n = 1'b0; commit = 1'b0; has_oob = 1'b0; fid_in = '0;
        ts_valid = 1'b0; ts_f = '0; ts_r = '0; ack = 1'b0;
        idle(3);
        chk("init_valid", valid_o, 1'b0);
        chk("init_drop", drop_o, 8'd0);
        chk("init_fid", fid_o, 16'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: single record, latency and handshake
        do_commit(1'b1, 16'h1234);
        idle(10);
        @(negedge clk);
        ts_valid = 1'b1; ts_f = 4'd3; ts_r = 28'h0ABCDEF;
        sb.push_back({16'h1234, 32'h30ABCDEF});
        @(negedge clk);
        ts_valid = 1'b0;
        chk("t1_lat1_valid", valid_o, 1'b0);
        @(negedge clk);
        chk("t1_lat2_valid", valid_o, 1'b1);
        recv(2);
        @(negedge clk);
        chk("t1_after_valid", valid_o, 1'b0);

        // 2: non-OOB frame consumes a timestamp silently
        do_commit(1'b1, 16'h00A0);
        do_commit(1'b0, 16'h00B0);
        do_commit(1'b1, 16'h00C0);
        do_ts(4'd1, 28'h0000111);
        sb.push_back({16'h00A0, 4'd1, 28'h0000111});
        do_ts(4'd2, 28'h0000222);
        do_ts(4'd4, 28'h0000333);
        sb.push_back({16'h00C0, 4'd4, 28'h0000333});
        recv(0);
        recv(1);
        idle(10);
        chk("t2_no_extra", valid_o, 1'b0);
        chk("t2_drop", drop_o, 8'd0);

        // 3: orphan timestamps and saturation
        do_ts(4'd0, 28'd0);
        idle(3);
        chk("t3_orphan_valid", valid_o, 1'b0);
        chk("t3_drop1", drop_o, 8'd1);
        @(negedge clk);
        ts_valid = 1'b1;
        repeat (253) @(negedge clk);
        ts_valid = 1'b0;
        chk("t3_drop254", drop_o, 8'd254);
        @(negedge clk);
        ts_valid = 1'b1;
        repeat (46) @(negedge clk);
        ts_valid = 1'b0;
        idle(1);
        chk("t3_drop_sat", drop_o, 8'd255);
        chk("t3_valid", valid_o, 1'b0);

        // 4: pending overflow
        do_reset();
        @(negedge clk);
        commit = 1'b1; has_oob = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            fid_in = 16'(i);
            @(negedge clk);
        end
        commit = 1'b0;
        idle(1);
        chk("t4_drop", drop_o, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            do_ts(4'(i + 8), 28'h0100000 + 28'(i));
            sb.push_back({16'(i), 4'(i + 8), 28'h0100000 + 28'(i)});
        end
        for (int i = 0; i < 4; i++) recv(0);
        do_ts(4'd0, 28'd0);
        idle(3);
        chk("t4_fifth_lost", drop_o, 8'd2);
        chk("t4_no_extra", valid_o, 1'b0);

        // 5: record FIFO overflow with consumer stalled
        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_commit(1'b1, 16'h0100 + 16'(i));
            do_ts(4'(i), 28'h0001000 + 28'(i));
            if (i < 8) sb.push_back({16'h0100 + 16'(i), 4'(i), 28'h0001000 + 28'(i)});
        end
        idle(2);
        chk("t5_drop", drop_o, 8'd1);
        chk("t5_valid", valid_o, 1'b1);
        chk("t5_fid_head", fid_o, 16'h0100);
        idle(5);
        chk("t5_fid_stable", fid_o, 16'h0100);
        chk("t5_ts_stable", tsval_o, {4'd0, 28'h0001000});
        for (int i = 0; i < 8; i++) recv(1);
        idle(10);
        chk("t5_drained", valid_o, 1'b0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // 6: same-cycle commit+ts, then reset during PRESENT
        do_reset();
        do_commit(1'b1, 16'h0066);
        idle(2);
        @(negedge clk);
        commit = 1'b1; has_oob = 1'b1; fid_in = 16'h0077;
        ts_valid = 1'b1; ts_f = 4'd5; ts_r = 28'h0000055;
        sb.push_back({16'h0066, 4'd5, 28'h0000055});
        @(negedge clk);
        commit = 1'b0; ts_valid = 1'b0;
        recv(0);
        do_ts(4'd6, 28'h0000066);
        wait_valid(ok);
        if (ok) begin
            chk("t6_retained_fid", fid_o, 16'h0077);
            chk("t6_retained_ts", tsval_o, {4'd6, 28'h0000066});
        end
        chk("t6_drop_pre", drop_o, 8'd0);
        do_reset();
        idle(10);
        chk("t6_no_stale", valid_o, 1'b0);
        do_ts(4'd0, 28'd0);
        idle(1);
        chk("t6_pend_flushed", drop_o, 8'd1);
        chk("t6_no_rec", valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
